// File: rtl/sa_skew_feeder.sv
// Systolic-array edge feeder: round-robin byte loader into per-lane FIFOs, then skewed vector streaming.
// Build option SKEW_FEEDER_ZERO_PAD_EN: stream without stalling, padding empty lanes with zero data.
module sa_skew_feeder #(
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_DATA = 8,
  parameter int W_ADDR = 4,
  parameter int W_LEN  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_dv,
  input  logic [W_DATA-1:0]     i_data,
  input  logic                  i_sel,
  input  logic                  i_start,
  input  logic [W_LEN-1:0]      i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [COL*W_DATA-1:0] o_north_data,
  output logic [COL-1:0]        o_north_dv,
  output logic [ROW*W_DATA-1:0] o_west_data,
  output logic [ROW-1:0]        o_west_dv
);

  localparam int LANES = ROW + COL;
  localparam int DEPTH = 1 << W_ADDR;
  localparam int MAXL  = (ROW > COL) ? ROW : COL;
  localparam int PW_N  = (COL > 1) ? $clog2(COL) : 1;
  localparam int PW_W  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int DW    = $clog2(MAXL) + 1;
  localparam logic [W_ADDR:0] FULL_CNT = (W_ADDR + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_DRAIN} state_t;

  state_t state_reg, state_next;

  logic [PW_N-1:0]  ptr_n_reg;
  logic [PW_W-1:0]  ptr_w_reg;
  logic [W_LEN-1:0] remaining_reg;
  logic [DW-1:0]    drain_cnt_reg;
  logic             done_reg;
  logic             overflow_reg;

  // Lanes 0..COL-1 are north, COL..COL+ROW-1 are west.
  logic [LANES-1:0]        lane_wr;
  logic [LANES-1:0]        lane_pop;
  logic [LANES-1:0]        lane_empty;
  logic [LANES-1:0]        lane_full;
  logic [LANES*W_DATA-1:0] lane_data;
  logic [LANES-1:0]        lane_dv;

  logic busy;
  logic start_ok;
  logic issue;
  logic drain_last;
  logic arm_ready;

`ifdef SKEW_FEEDER_ZERO_PAD_EN
  assign arm_ready = 1'b1;
  assign lane_pop  = {LANES{issue}} & ~lane_empty;
`else
  assign arm_ready = ~|lane_empty;
  assign lane_pop  = {LANES{issue}};
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start_ok) state_next = S_ARM;
      S_ARM:    if (arm_ready) state_next = S_STREAM;
      S_STREAM: if (issue && (remaining_reg == W_LEN'(1))) state_next = S_DRAIN;
      S_DRAIN:  if (drain_last) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy       = 1'b0;
    start_ok   = 1'b0;
    issue      = 1'b0;
    drain_last = 1'b0;
    case (state_reg)
      S_IDLE: start_ok = i_start && (i_len != '0);
      S_ARM:  busy = 1'b1;
      S_STREAM: begin
        busy = 1'b1;
`ifdef SKEW_FEEDER_ZERO_PAD_EN
        issue = 1'b1;
`else
        issue = ~|lane_empty;
`endif
      end
      S_DRAIN: begin
        busy       = 1'b1;
        drain_last = (drain_cnt_reg == DW'(MAXL - 1));
      end
      default: busy = 1'b0;
    endcase
  end

  // ---------------- run control / status ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining_reg <= '0;
      drain_cnt_reg <= '0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (start_ok) begin
        remaining_reg <= i_len;
      end else if (issue) begin
        remaining_reg <= remaining_reg - W_LEN'(1);
      end
      drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + DW'(1) : '0;
      done_reg      <= drain_last;
      if (|(lane_wr & lane_full & ~lane_pop)) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Pointers advance even on a dropped byte so later bytes stay lane-aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_n_reg <= '0;
      ptr_w_reg <= '0;
    end else if (i_rx_dv) begin
      if (!i_sel) begin
        ptr_n_reg <= (ptr_n_reg == PW_N'(COL - 1)) ? '0 : ptr_n_reg + PW_N'(1);
      end else begin
        ptr_w_reg <= (ptr_w_reg == PW_W'(ROW - 1)) ? '0 : ptr_w_reg + PW_W'(1);
      end
    end
  end

  // ---------------- per-lane FIFO + skew ----------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int SK = (gi < COL) ? gi : gi - COL;

    logic [W_DATA-1:0] mem [DEPTH];
    logic [W_DATA-1:0] rd_word_reg;
    logic [W_ADDR-1:0] wr_addr_reg;
    logic [W_ADDR-1:0] rd_addr_reg;
    logic [W_ADDR:0]   count_reg;
    logic              popped_reg;
    logic              dv0_reg;
    logic              wr_ok;
    logic [W_DATA-1:0] stage0_data;

    if (gi < COL) begin : g_north_sel
      assign lane_wr[gi] = i_rx_dv && !i_sel && (ptr_n_reg == PW_N'(gi));
    end else begin : g_west_sel
      assign lane_wr[gi] = i_rx_dv && i_sel && (ptr_w_reg == PW_W'(gi - COL));
    end

    assign lane_empty[gi] = (count_reg == '0);
    assign lane_full[gi]  = (count_reg == FULL_CNT);
    assign wr_ok          = lane_wr[gi] && (!lane_full[gi] || lane_pop[gi]);
    // The RAM read word is free-running; popped_reg gates it so bubbles and pads read as zero.
    assign stage0_data    = popped_reg ? rd_word_reg : '0;

    always_ff @(posedge i_clk) begin
      if (wr_ok) begin
        mem[wr_addr_reg] <= i_data;
      end
      rd_word_reg <= mem[rd_addr_reg];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wr_addr_reg <= '0;
        rd_addr_reg <= '0;
        count_reg   <= '0;
        popped_reg  <= 1'b0;
        dv0_reg     <= 1'b0;
      end else begin
        if (wr_ok) begin
          wr_addr_reg <= wr_addr_reg + W_ADDR'(1);
        end
        if (lane_pop[gi]) begin
          rd_addr_reg <= rd_addr_reg + W_ADDR'(1);
        end
        if (wr_ok && !lane_pop[gi]) begin
          count_reg <= count_reg + (W_ADDR + 1)'(1);
        end else if (!wr_ok && lane_pop[gi]) begin
          count_reg <= count_reg - (W_ADDR + 1)'(1);
        end
        popped_reg <= lane_pop[gi];
        dv0_reg    <= issue;
      end
    end

    if (SK == 0) begin : g_direct
      assign lane_data[gi*W_DATA +: W_DATA] = stage0_data;
      assign lane_dv[gi]                    = dv0_reg;
    end else begin : g_skew
      logic [W_DATA-1:0] sh_data_reg [SK];
      logic [SK-1:0]     sh_dv_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int j = 0; j < SK; j++) begin
            sh_data_reg[j] <= '0;
          end
          sh_dv_reg <= '0;
        end else begin
          sh_data_reg[0] <= stage0_data;
          sh_dv_reg[0]   <= dv0_reg;
          for (int j = 1; j < SK; j++) begin
            sh_data_reg[j] <= sh_data_reg[j-1];
            sh_dv_reg[j]   <= sh_dv_reg[j-1];
          end
        end
      end

      assign lane_data[gi*W_DATA +: W_DATA] = sh_data_reg[SK-1];
      assign lane_dv[gi]                    = sh_dv_reg[SK-1];
    end
  end

  assign o_busy       = busy;
  assign o_done       = done_reg;
  assign o_overflow   = overflow_reg;
  assign o_north_data = lane_data[COL*W_DATA-1:0];
  assign o_north_dv   = lane_dv[COL-1:0];
  assign o_west_data  = lane_data[LANES*W_DATA-1:COL*W_DATA];
  assign o_west_dv    = lane_dv[LANES-1:COL];

endmodule
